// File: rtl/bit_scan_iter_if.sv
// Handshake bundle for bit_scan_iter: vector input channel and beat output channel.
interface bit_scan_iter_if #(
    parameter int NUM_BITS = 32
);
    localparam int POS_W = $clog2(NUM_BITS);

    logic                in_valid;
    logic                in_ready;
    logic [NUM_BITS-1:0] in_vec;
    logic                in_mode;
    logic                out_valid;
    logic                out_ready;
    logic [POS_W-1:0]    out_pos;
    logic [POS_W:0]      out_idx;
    logic                out_last;
    logic                out_none;

    // Producer/consumer side (testbench or upstream logic)
    modport master (
        output in_valid, in_vec, in_mode, out_ready,
        input  in_ready, out_valid, out_pos, out_idx, out_last, out_none
    );

    // Scanner side
    modport slave (
        input  in_valid, in_vec, in_mode, out_ready,
        output in_ready, out_valid, out_pos, out_idx, out_last, out_none
    );
endinterface

// File: rtl/bit_scan_iter.sv
// Sequential set-bit scanner: captures a vector, then emits the index of each
// set bit one beat at a time, lowest-first (mode 0) or highest-first (mode 1).
module bit_scan_iter #(
    parameter int NUM_BITS = 32
) (
    input  logic           clk,
    input  logic           rst,
    bit_scan_iter_if.slave bus
);
    localparam int POS_W = $clog2(NUM_BITS);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t              r_state;
    logic [NUM_BITS-1:0] r_residue;
    logic                r_mode;
    logic [POS_W:0]      r_idx;
    logic                r_none;

    logic [NUM_BITS-1:0] w_iso;
    logic [POS_W-1:0]    w_lo_pos;
    logic [POS_W-1:0]    w_hi_pos;
    logic [POS_W-1:0]    w_pos;
    logic                w_last;
    logic                w_scan;

    // Isolate the lowest set bit of the residue and encode its index.
    always_comb begin
        w_iso    = r_residue & ~(r_residue - NUM_BITS'(1));
        w_lo_pos = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            if (w_iso[i]) begin
                w_lo_pos = w_lo_pos | POS_W'(i);
            end
        end
    end

    // Encode the index of the highest set bit; later iterations override earlier ones.
    always_comb begin
        w_hi_pos = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            if (r_residue[i]) begin
                w_hi_pos = POS_W'(i);
            end
        end
    end

    // Select the current beat and detect the final beat (at most one bit left).
    always_comb begin
        w_pos  = r_mode ? w_hi_pos : w_lo_pos;
        w_last = ((r_residue & (r_residue - NUM_BITS'(1))) == '0);
        w_scan = (r_state == SCAN);
    end

    // Outputs decode registered state only; gated to zero outside SCAN.
    always_comb begin
        bus.in_ready  = (r_state == IDLE) && !rst;
        bus.out_valid = w_scan;
        bus.out_pos   = w_scan ? w_pos : '0;
        bus.out_idx   = w_scan ? r_idx : '0;
        bus.out_last  = w_scan && w_last;
        bus.out_none  = w_scan && r_none;
    end

    // Capture/scan state machine: IDLE accepts a vector, SCAN retires one set bit per handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_residue <= '0;
            r_mode    <= 1'b0;
            r_idx     <= '0;
            r_none    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates here so every branch reads the pre-edge residue/index.
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_residue <= bus.in_vec;
                        r_mode    <= bus.in_mode;
                        r_idx     <= '0;
                        r_none    <= (bus.in_vec == '0);
                        r_state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.out_ready) begin
                        r_residue[w_pos] <= 1'b0;
                        r_idx            <= r_idx + {{POS_W{1'b0}}, 1'b1};
                        if (w_last) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_scan_iter.sv
// Scoreboard bench for bit_scan_iter: an 8-bit and a 32-bit instance share clk/rst.
module tb_bit_scan_iter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bit_scan_iter_if #(.NUM_BITS(8))  b8 ();
    bit_scan_iter_if #(.NUM_BITS(32)) b32 ();

    bit_scan_iter #(.NUM_BITS(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    bit_scan_iter #(.NUM_BITS(32)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    typedef struct packed {
        logic [9:0]  pos;
        logic [10:0] idx;
        logic        last;
        logic        none;
    } beat_t;

    beat_t sb8[$];
    beat_t sb32[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int pos, input int idx, input bit last, input bit none);
        beat_t b;
        b.pos  = 10'(pos);
        b.idx  = 11'(idx);
        b.last = last;
        b.none = none;
        return b;
    endfunction

    // Monitor for the 8-bit instance: pops on each handshake, checks stall stability and the idle gap.
    initial begin
        beat_t hold;
        bit    have_hold = 1'b0;
        bit    idle_chk  = 1'b0;
        forever begin
            beat_t cur;
            beat_t exp;
            @(negedge clk);
            if (rst) begin
                have_hold = 1'b0;
                idle_chk  = 1'b0;
            end else begin
                cur = mk(int'(b8.out_pos), int'(b8.out_idx), b8.out_last, b8.out_none);
                if (idle_chk) begin
                    check("gap8_in_ready", 64'(b8.in_ready), 64'(1));
                    check("gap8_out_valid", 64'(b8.out_valid), 64'(0));
                    idle_chk = 1'b0;
                end
                if (have_hold) begin
                    check("stall8_stable", 64'({b8.out_valid, cur}), 64'({1'b1, hold}));
                    have_hold = 1'b0;
                end
                if (b8.out_valid) begin
                    if (b8.out_ready) begin
                        if (sb8.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL beat8_unexpected: got %0h expected none", cur);
                        end else begin
                            exp = sb8.pop_front();
                            check("beat8", 64'(cur), 64'(exp));
                            if (exp.last) idle_chk = 1'b1;
                        end
                    end else begin
                        hold      = cur;
                        have_hold = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor for the 32-bit instance.
    initial begin
        beat_t hold;
        bit    have_hold = 1'b0;
        forever begin
            beat_t cur;
            beat_t exp;
            @(negedge clk);
            if (rst) begin
                have_hold = 1'b0;
            end else begin
                cur = mk(int'(b32.out_pos), int'(b32.out_idx), b32.out_last, b32.out_none);
                if (have_hold) begin
                    check("stall32_stable", 64'({b32.out_valid, cur}), 64'({1'b1, hold}));
                    have_hold = 1'b0;
                end
                if (b32.out_valid) begin
                    if (b32.out_ready) begin
                        if (sb32.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL beat32_unexpected: got %0h expected none", cur);
                        end else begin
                            exp = sb32.pop_front();
                            check("beat32", 64'(cur), 64'(exp));
                        end
                    end else begin
                        hold      = cur;
                        have_hold = 1'b1;
                    end
                end
            end
        end
    end

    // Present a vector on the 8-bit instance and return #1 after the capture edge.
    task automatic send8(input logic [7:0] vec, input logic mode);
        int n = 0;
        b8.in_vec   = vec;
        b8.in_mode  = mode;
        b8.in_valid = 1'b1;
        while (!b8.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("send8_ready", 64'(b8.in_ready), 64'(1));
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        check("latency8_out_valid", 64'(b8.out_valid), 64'(1));
    endtask

    task automatic send32(input logic [31:0] vec, input logic mode);
        int n = 0;
        b32.in_vec   = vec;
        b32.in_mode  = mode;
        b32.in_valid = 1'b1;
        while (!b32.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("send32_ready", 64'(b32.in_ready), 64'(1));
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        check("latency32_out_valid", 64'(b32.out_valid), 64'(1));
    endtask

    // Wait until every expected beat is consumed and the block is back in IDLE.
    task automatic wait_idle8(input bit rnd);
        int n = 0;
        while (!(sb8.size() == 0 && b8.in_ready) && n < 300) begin
            @(posedge clk); #1;
            if (rnd) b8.out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check("drain8", 64'({sb8.size() == 0, b8.in_ready}), 64'(2'b11));
    endtask

    task automatic wait_idle32();
        int n = 0;
        while (!(sb32.size() == 0 && b32.in_ready) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain32", 64'({sb32.size() == 0, b32.in_ready}), 64'(2'b11));
    endtask

    initial begin
        rst           = 1'b1;
        b8.in_valid   = 1'b0;
        b8.in_vec     = '0;
        b8.in_mode    = 1'b0;
        b8.out_ready  = 1'b0;
        b32.in_valid  = 1'b0;
        b32.in_vec    = '0;
        b32.in_mode   = 1'b0;
        b32.out_ready = 1'b0;

        // Reset state
        #2;
        check("rst_in_ready", 64'(b8.in_ready), 64'(0));
        check("rst_outs8", 64'({b8.out_valid, b8.out_pos, b8.out_idx, b8.out_last, b8.out_none}), 64'(0));
        check("rst_outs32", 64'({b32.out_valid, b32.out_pos, b32.out_idx, b32.out_last, b32.out_none}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(b8.in_ready), 64'(1));

        // 8'b1010_0100, lowest first
        b8.out_ready = 1'b1;
        sb8.push_back(mk(2, 0, 1'b0, 1'b0));
        sb8.push_back(mk(5, 1, 1'b0, 1'b0));
        sb8.push_back(mk(7, 2, 1'b1, 1'b0));
        send8(8'hA4, 1'b0);
        wait_idle8(1'b0);

        // Same vector, highest first
        sb8.push_back(mk(7, 0, 1'b0, 1'b0));
        sb8.push_back(mk(5, 1, 1'b0, 1'b0));
        sb8.push_back(mk(2, 2, 1'b1, 1'b0));
        send8(8'hA4, 1'b1);
        wait_idle8(1'b0);

        // All-zero vector: single none beat
        sb8.push_back(mk(0, 0, 1'b1, 1'b1));
        send8(8'h00, 1'b0);
        wait_idle8(1'b0);

        // All-ones with random back-pressure
        b8.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) sb8.push_back(mk(i, i, i == 7, 1'b0));
        send8(8'hFF, 1'b0);
        wait_idle8(1'b1);
        b8.out_ready = 1'b1;

        // Reset after the second beat handshake
        sb8.push_back(mk(0, 0, 1'b0, 1'b0));
        sb8.push_back(mk(1, 1, 1'b0, 1'b0));
        send8(8'hFF, 1'b0);
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(b8.out_valid), 64'(0));
        check("midrst_in_ready", 64'(b8.in_ready), 64'(0));
        check("midrst_outs", 64'({b8.out_pos, b8.out_idx, b8.out_last}), 64'(0));
        check("midrst_sb_empty", 64'(sb8.size()), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_recover_in_ready", 64'(b8.in_ready), 64'(1));
        check("midrst_no_beat", 64'(b8.out_valid), 64'(0));
        sb8.push_back(mk(7, 0, 1'b1, 1'b0));
        send8(8'h80, 1'b0);
        wait_idle8(1'b0);

        // 32-bit: highest first, input changes during scan ignored
        b32.out_ready = 1'b0;
        sb32.push_back(mk(31, 0, 1'b0, 1'b0));
        sb32.push_back(mk(0, 1, 1'b1, 1'b0));
        send32(32'h8000_0001, 1'b1);
        b32.in_mode = 1'b0;
        b32.in_vec  = 32'h0000_FFFF;
        repeat (3) begin
            @(posedge clk); #1;
        end
        b32.out_ready = 1'b1;
        wait_idle32();

        repeat (3) @(posedge clk);
        #1;
        check("final_idle8", 64'({b8.out_valid, b8.in_ready}), 64'(2'b01));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
